// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the 16-bit MIPS pipeline register file.
// Provides default data/address widths, the hardwired-zero register index
// and typedefs for the default (16-bit x 4) configuration.
package mips_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned REG_ZERO = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundle between decode/issue/writeback and the register file.
//   rd_addr/rd_data/rd_busy : NUM_RD read ports, port i in slice i
//   wr_en/wr_addr/wr_data   : writeback strobe, register and data
//   iss_valid/iss_addr      : issue request marking a pending destination
//   iss_ready               : issue accepted this cycle if iss_valid
//   busy_any                : OR of all scoreboard busy bits
// master = requester side, slave = register file.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     busy_any;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr,
    input  rd_data, rd_busy, iss_ready, busy_any
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr,
    output rd_data, rd_busy, iss_ready, busy_any
  );

endinterface

// File: rtl/sb_busy_table.sv
// sb_busy_table: per-register busy scoreboard.
//   clock, reset_n      : clock, asynchronous active-low reset (clears all bits)
//   set_en, set_addr    : mark register pending (issue)
//   clr_en, clr_addr    : clear pending bit (writeback)
//   busy                : registered busy vector, one bit per register
//   busy_any            : OR of busy
// Set has priority over clear when both target the same register.
module sb_busy_table #(
  parameter int unsigned ADDR_W = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [2**ADDR_W-1:0]   busy,
  output logic                   busy_any
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (set_en && set_addr == ADDR_W'(i)) begin
          busy[i] <= 1'b1;
        end else if (clr_en && clr_addr == ADDR_W'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_any = |busy;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: DATA_W x 2**ADDR_W register file with NUM_RD combinational
// read ports, write-to-read bypass and an issue/writeback busy scoreboard.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (registers and scoreboard cleared)
//   bus     : regfile_sb_if slave modport (read ports, writeback, issue,
//             iss_ready, busy_any)
// Register 0 reads as zero, ignores writes and never becomes busy.
module regfile_sb #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned NUM_RD = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  regfile_sb_if.slave  bus
);

  import mips_pkg::*;

  localparam int unsigned       NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO     = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_act;
  logic                iss_act;

  assign wr_act = bus.wr_en && (bus.wr_addr != ZERO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else if (wr_act) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // A writeback to the issue target frees it in the same cycle, so the
  // re-issue may coincide with the write.
  assign bus.iss_ready = (bus.iss_addr == ZERO) ||
                         !busy[bus.iss_addr] ||
                         (bus.wr_en && (bus.wr_addr == bus.iss_addr));

  assign iss_act = bus.iss_valid && bus.iss_ready && (bus.iss_addr != ZERO);

  sb_busy_table #(
    .ADDR_W (ADDR_W)
  ) u_busy (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en   (iss_act),
    .set_addr (bus.iss_addr),
    .clr_en   (wr_act),
    .clr_addr (bus.wr_addr),
    .busy     (busy),
    .busy_any (bus.busy_any)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign r = bus.rd_addr[i*ADDR_W +: ADDR_W];

    // Bypass is gated by reset_n so a held reset reads zero whatever wr_* carry.
    always_comb begin
      data = '0;
      pend = 1'b0;
      if (r == ZERO) begin
        data = '0;
        pend = 1'b0;
      end else if (reset_n && bus.wr_en && (bus.wr_addr == r)) begin
        data = bus.wr_data;
        pend = 1'b0;
      end else begin
        data = regs[r];
        pend = busy[r];
      end
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[i]                  = pend;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  import mips_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(2), .NUM_RD(2)) a ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(3)) b ();

  regfile_sb #(.DATA_W(16), .ADDR_W(2), .NUM_RD(2)) dut_a (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (a)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(3), .NUM_RD(3)) dut_b (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model of dut_a: register contents and pending destinations.
  reg_data_t  m_regs [4];
  logic [3:0] m_busy;

  function automatic bit m_ready();
    return (a.iss_addr == 2'd0) || !m_busy[a.iss_addr] ||
           (a.wr_en && a.wr_addr == a.iss_addr);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit rdy;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) m_regs[k] = '0;
      m_busy = '0;
    end else begin
      rdy = m_ready();
      if (a.wr_en && a.wr_addr != 2'd0) begin
        m_regs[a.wr_addr] = a.wr_data;
        m_busy[a.wr_addr] = 1'b0;
      end
      if (a.iss_valid && rdy && a.iss_addr != 2'd0) m_busy[a.iss_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [1:0]  ra;
    logic [15:0] ed;
    logic        eb;
    for (int i = 0; i < 2; i++) begin
      ra = a.rd_addr[i*2 +: 2];
      if (!rst_n || ra == 2'd0) begin
        ed = '0; eb = 1'b0;
      end else if (a.wr_en && a.wr_addr == ra) begin
        ed = a.wr_data; eb = 1'b0;
      end else begin
        ed = m_regs[ra]; eb = m_busy[ra];
      end
      chk($sformatf("cmp rd_data%0d", i), 32'(a.rd_data[i*16 +: 16]), 32'(ed));
      chk($sformatf("cmp rd_busy%0d", i), 32'(a.rd_busy[i]), 32'(eb));
    end
    chk("cmp iss_ready", 32'(a.iss_ready), 32'(!rst_n ? 1'b1 : m_ready()));
    chk("cmp busy_any", 32'(a.busy_any), 32'(|m_busy));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a.wr_en = 1'b0; a.wr_addr = '0; a.wr_data = '0;
    a.iss_valid = 1'b0; a.iss_addr = '0;
  endtask

  task automatic idle_b();
    b.wr_en = 1'b0; b.wr_addr = '0; b.wr_data = '0;
    b.iss_valid = 1'b0; b.iss_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with arbitrary activity on the inputs.
    a.wr_en = 1'b1; a.wr_addr = 2'd2; a.wr_data = 16'hABCD;
    a.iss_valid = 1'b1; a.iss_addr = 2'd3;
    a.rd_addr = {2'd3, 2'd2};
    idle_b();
    b.rd_addr = '0;
    #5;
    chk("rst rd_data0", 32'(a.rd_data[15:0]), 32'h0);
    chk("rst rd_data1", 32'(a.rd_data[31:16]), 32'h0);
    chk("rst rd_busy", 32'(a.rd_busy), 32'h0);
    chk("rst busy_any", 32'(a.busy_any), 32'h0);
    chk("rst iss_ready", 32'(a.iss_ready), 32'h1);
    cyc(); cyc();
    rst_n = 1'b1;
    idle_a();
    a.rd_addr = {2'd2, 2'd1};
    #1;
    chk("post-rst r1", 32'(a.rd_data[15:0]), 32'h0);
    chk("post-rst r2", 32'(a.rd_data[31:16]), 32'h0);
    a.rd_addr = {2'd0, 2'd3};
    #1;
    chk("post-rst r3", 32'(a.rd_data[15:0]), 32'h0);

    // Write with same-cycle bypass, then stored value.
    cyc();
    a.wr_en = 1'b1; a.wr_addr = 2'd2; a.wr_data = 16'h1234;
    a.rd_addr = {2'd0, 2'd2};
    #1;
    chk("bypass r2", 32'(a.rd_data[15:0]), 32'h1234);
    chk("bypass busy", 32'(a.rd_busy[0]), 32'h0);
    cyc();
    idle_a();
    #1;
    chk("stored r2", 32'(a.rd_data[15:0]), 32'h1234);

    // Register 0 ignores writes and issues.
    cyc();
    a.wr_en = 1'b1; a.wr_addr = 2'd0; a.wr_data = 16'hFFFF;
    a.iss_valid = 1'b1; a.iss_addr = 2'd0;
    a.rd_addr = {2'd0, 2'd0};
    #1;
    chk("r0 data", 32'(a.rd_data[15:0]), 32'h0);
    chk("r0 ready", 32'(a.iss_ready), 32'h1);
    cyc();
    idle_a();
    #1;
    chk("r0 data after", 32'(a.rd_data[15:0]), 32'h0);
    chk("r0 busy after", 32'(a.rd_busy[0]), 32'h0);
    chk("r0 busy_any", 32'(a.busy_any), 32'h0);

    // Scoreboard stall on r3.
    cyc();
    a.iss_valid = 1'b1; a.iss_addr = 2'd3;
    a.rd_addr = {2'd3, 2'd0};
    #1;
    chk("iss r3 ready", 32'(a.iss_ready), 32'h1);
    cyc();
    #1;
    chk("r3 busy", 32'(a.rd_busy[1]), 32'h1);
    chk("r3 busy_any", 32'(a.busy_any), 32'h1);
    chk("r3 stall", 32'(a.iss_ready), 32'h0);
    cyc();
    #1;
    chk("r3 still stalled", 32'(a.iss_ready), 32'h0);
    chk("r3 still busy", 32'(a.rd_busy[1]), 32'h1);
    cyc();
    a.wr_en = 1'b1; a.wr_addr = 2'd3; a.wr_data = 16'h0042;
    #1;
    chk("wb+reissue ready", 32'(a.iss_ready), 32'h1);
    chk("wb+reissue bypass", 32'(a.rd_data[31:16]), 32'h0042);
    chk("wb+reissue rd_busy", 32'(a.rd_busy[1]), 32'h0);
    cyc();
    idle_a();
    #1;
    chk("r3 stored", 32'(a.rd_data[31:16]), 32'h0042);
    chk("r3 busy kept", 32'(a.rd_busy[1]), 32'h1);
    chk("r3 busy_any kept", 32'(a.busy_any), 32'h1);
    cyc();
    a.wr_en = 1'b1; a.wr_addr = 2'd3; a.wr_data = 16'h0055;
    cyc();
    idle_a();
    #1;
    chk("r3 cleared", 32'(a.busy_any), 32'h0);
    chk("r3 final", 32'(a.rd_data[31:16]), 32'h0055);

    // Independent write r1 and issue r2; plain write to non-busy register.
    cyc();
    a.wr_en = 1'b1; a.wr_addr = 2'd1; a.wr_data = 16'h1111;
    a.iss_valid = 1'b1; a.iss_addr = 2'd2;
    a.rd_addr = {2'd2, 2'd1};
    cyc();
    idle_a();
    #1;
    chk("indep r1", 32'(a.rd_data[15:0]), 32'h1111);
    chk("indep r1 busy", 32'(a.rd_busy[0]), 32'h0);
    chk("indep r2 busy", 32'(a.rd_busy[1]), 32'h1);
    cyc();
    a.wr_en = 1'b1; a.wr_addr = 2'd1; a.wr_data = 16'h2222;
    cyc();
    a.wr_en = 1'b1; a.wr_addr = 2'd2; a.wr_data = 16'h2020;
    cyc();
    idle_a();
    #1;
    chk("plain r1", 32'(a.rd_data[15:0]), 32'h2222);
    chk("plain r1 busy", 32'(a.rd_busy[0]), 32'h0);
    chk("r2 written", 32'(a.rd_data[31:16]), 32'h2020);

    // Multi-port configuration.
    cyc();
    b.wr_en = 1'b1; b.wr_addr = 3'd5; b.wr_data = 32'hDEADBEEF;
    cyc();
    b.wr_addr = 3'd7; b.wr_data = 32'h1;
    b.rd_addr = {3'd5, 3'd7, 3'd5};
    #1;
    chk("mp bypass r7", b.rd_data[63:32], 32'h1);
    cyc();
    idle_b();
    #1;
    chk("mp port0", b.rd_data[31:0], 32'hDEADBEEF);
    chk("mp port1", b.rd_data[63:32], 32'h1);
    chk("mp port2", b.rd_data[95:64], 32'hDEADBEEF);

    // Reset pulse mid-operation.
    cyc();
    a.iss_valid = 1'b1; a.iss_addr = 2'd1;
    cyc();
    a.iss_addr = 2'd2;
    cyc();
    idle_a();
    #1;
    chk("pre-rst busy_any", 32'(a.busy_any), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst busy_any", 32'(a.busy_any), 32'h0);
    chk("mid-rst r1", 32'(a.rd_data[15:0]), 32'h0);
    chk("mid-rst r2", 32'(a.rd_data[31:16]), 32'h0);
    chk("mid-rst mp r5", b.rd_data[31:0], 32'h0);
    #1;
    rst_n = 1'b1;
    a.iss_valid = 1'b1; a.iss_addr = 2'd1;
    #1;
    chk("post-rst iss r1", 32'(a.iss_ready), 32'h1);
    cyc();
    idle_a();
    #1;
    chk("post-rst r1 busy", 32'(a.rd_busy[0]), 32'h1);
    chk("post-rst busy_any", 32'(a.busy_any), 32'h1);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
